onehot_pulse_decoder: RTL and testbench
=======================================

# onehot_pulse_decoder

Registered binary-to-one-hot decoder that takes an encoded index with a valid/ready handshake and drives the matching one-hot line for a fixed number of cycles, then idles for a fixed gap. It sits on the receiving end of the priority-encoder path: the encoder's 2-bit code and its any-bit-set flag come in, and a timed one-hot strobe goes out to downstream enables. It is the decoding counterpart of the 4-to-2 priority encoder, with pulse timing and back-pressure added.

## Interface
- SEL_W, 2: code width. Output width N_OUT = 2**SEL_W, derived and not overridable.
- PULSE_LEN, 4: cycles the one-hot output is held. Must be at least 1.
- GAP_LEN, 1: idle cycles after each pulse. Must be at least 0.
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  request present.
- in_code  input  SEL_W  index to decode.
- in_ready  output  1  request accepted on the edge where in_valid && in_ready.
- y  output  N_OUT  one-hot output, registered. All zero when not driving.
- y_valid  output  1  high exactly when y is non-zero.
- busy  output  1  state != IDLE, or pending entry held.
- done  output  1  one-cycle pulse marking pulse completion.

## Operation
- States: IDLE, DRIVE, GAP. Encoding constants live in the package.
- IDLE:
  - in_ready = 1.
  - On accept, capture in_code. Next state DRIVE, counter = PULSE_LEN-1.
- DRIVE:
  - y = 1 << code, y_valid = 1.
  - The counter decrements each cycle.
  - When the counter reaches 0: go to GAP with counter = GAP_LEN-1 if GAP_LEN > 0, else go to IDLE.
- GAP:
  - y = 0.
  - When the counter reaches 0, go to IDLE.
- done is high in the first cycle after the last DRIVE cycle. This cycle is either the first GAP cycle or, when GAP_LEN = 0, the following state's cycle.
- Exactly one bit of y is ever set. No overlap between consecutive codes.
- Counter width is $clog2(max(PULSE_LEN, GAP_LEN) + 1).
- Without the queue feature, in_ready = 0 in DRIVE and GAP.
- in_ready is forced to 0 while rst is high.
- Reset state:
  - state = IDLE.
  - y, y_valid, done, busy = 0.
  - Pending entry cleared.
  - in_ready = 1 after rst deasserts.
- Reset mid-operation: y clears asynchronously, any in-flight done is suppressed, and the pending entry is discarded.

## Timing
- Cycle numbering: the accept cycle is cycle 0.
- Cycles 1..P: DRIVE, where P = PULSE_LEN.
- Cycle P+1: done is high.
- Cycles P+1..P+G: GAP, where G = GAP_LEN.
- Cycle P+G+1: IDLE, in_ready = 1.
- Without the queue, the minimum spacing between accepts is P+G+1 cycles.
- Latency from accept to the first y cycle is 1 cycle.
- in_code is sampled only on accept. Later changes have no effect.

## Configuration
- Macro: ONEHOT_DEC_QUEUE_EN.
- When defined:
  - Adds a one-entry pending register. in_ready = !pending_full in every state.
  - A request accepted in DRIVE or GAP is stored in the pending register.
  - On the cycle the block would enter IDLE, it enters DRIVE with the pending code instead. The pending entry is cleared that cycle and may be refilled on the same edge.
  - Request spacing becomes P+G cycles, so P = 1, G = 0 sustains one code per cycle.
  - busy includes pending_full.
- When undefined: no pending register, and behaviour is as described in Operation.

## Structure
- Package onehot_dec_pkg holds:
  - State encodings IDLE/DRIVE/GAP.
  - The default PULSE_LEN and GAP_LEN constants.
  - A function giving the counter width.
- One sub-module, pulse_timer: a loadable down-counter with a zero flag, instantiated once and shared by DRIVE and GAP.

## Test plan
All scenarios use P = 4 and G = 1 unless stated.
- Reset: hold rst high for 3 cycles -> y = 0000, y_valid = 0, busy = 0, done = 0, in_ready = 0. Release rst -> in_ready = 1.
- Single request: code 2'b10 accepted in cycle 0 -> y = 0100 in cycles 1–4, y = 0000 and done = 1 in cycle 5, in_ready = 1 in cycle 6.
- Sweep: codes 0, 1, 2, 3 sent back-to-back -> y = 0001, 0010, 0100, 1000 in order. Each is held 4 cycles, with popcount(y) ≤ 1 throughout.
- in_valid held with code 3 during DRIVE of code 0:
  - Macro undefined: in_ready stays 0 and code 3 is accepted in cycle 6, so y = 1000 from cycle 7.
  - Macro defined: code 3 is taken in cycle 1 and y = 1000 from cycle 6.
- Reset asserted in cycle 2 of DRIVE -> y = 0000 immediately, no done pulse, pending entry dropped, IDLE after release.
- P = 1, G = 0 with the macro defined and a continuous stream 0, 1, 2, 3 -> y changes every cycle: 0001, 0010, 0100, 1000. in_ready stays 1 throughout.

Source files
------------

// File: rtl/onehot_pulse_decoder_pkg.sv
// onehot_dec_pkg: state encodings, default timing constants and counter width helper for onehot_pulse_decoder
package onehot_dec_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, GAP = 2'd2} state_e;
  localparam int DEF_PULSE_LEN = 4;
  localparam int DEF_GAP_LEN = 1;
  function automatic int cnt_w(input int p, input int g);
    return $clog2((p > g ? p : g) + 1);
  endfunction
endpackage

// File: rtl/onehot_pulse_decoder_pulse_timer.sv
// pulse_timer: loadable down-counter that stops at zero and flags it
module pulse_timer
  import onehot_dec_pkg::*;
#(
  parameter int W = cnt_w(DEF_PULSE_LEN, DEF_GAP_LEN)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign zero_o = cnt_q == '0;
  assign cnt_d = load_i ? load_val_i : zero_o ? cnt_q : cnt_q - W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/onehot_pulse_decoder.sv
// onehot_pulse_decoder: valid/ready code in, timed registered one-hot pulse out (ONEHOT_DEC_QUEUE_EN adds a one-entry pending slot)
module onehot_pulse_decoder
  import onehot_dec_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int PULSE_LEN = DEF_PULSE_LEN,
  parameter int GAP_LEN = DEF_GAP_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [SEL_W-1:0]      in_code,
  output logic                  in_ready,
  output logic [2**SEL_W-1:0]   y,
  output logic                  y_valid,
  output logic                  busy,
  output logic                  done
);
  localparam int N_OUT = 2**SEL_W;
  localparam int W = cnt_w(PULSE_LEN, GAP_LEN);
  localparam logic [W-1:0] P_LD = W'(PULSE_LEN - 1);
  localparam logic [W-1:0] G_LD = W'(GAP_LEN > 0 ? GAP_LEN - 1 : 0);
  localparam bit HAS_GAP = GAP_LEN > 0;
  state_e state_q, state_d;
  logic [SEL_W-1:0] code_q, code_d, pend_code;
  logic [N_OUT-1:0] y_q, y_d;
  logic done_q, done_d, ld, zero, accept, fin, pend_full;
  logic [W-1:0] ld_val;
  pulse_timer #(.W(W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ld),
    .load_val_i (ld_val),
    .zero_o     (zero)
  );
  assign accept = in_valid && in_ready;
  assign fin = state_q == IDLE || (zero && (state_q == GAP || (state_q == DRIVE && !HAS_GAP)));
`ifdef ONEHOT_DEC_QUEUE_EN
  logic pend_full_q, pend_full_d;
  logic [SEL_W-1:0] pend_code_q, pend_code_d;
  assign pend_full_d = fin ? pend_full_q && accept : pend_full_q || accept;
  assign pend_code_d = accept ? in_code : pend_code_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend_full_q <= 1'b0;
      pend_code_q <= '0;
    end else begin
      pend_full_q <= pend_full_d;
      pend_code_q <= pend_code_d;
    end
  assign pend_full = pend_full_q;
  assign pend_code = pend_code_q;
  assign in_ready = !rst && !pend_full_q;
`else
  assign pend_full = 1'b0;
  assign pend_code = '0;
  assign in_ready = !rst && state_q == IDLE;
`endif
  always_comb begin
    state_d = state_q;
    code_d = code_q;
    ld = 1'b0;
    ld_val = P_LD;
    done_d = state_q == DRIVE && zero;
    if (state_q == DRIVE && zero && HAS_GAP) begin
      state_d = GAP;
      ld = 1'b1;
      ld_val = G_LD;
    end else if (fin) begin
      state_d = pend_full || accept ? DRIVE : IDLE;
      code_d = pend_full ? pend_code : accept ? in_code : code_q;
      ld = pend_full || accept;
    end
    y_d = state_d == DRIVE ? N_OUT'(1) << code_d : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      code_q <= '0;
      y_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q <= code_d;
      y_q <= y_d;
      done_q <= done_d;
    end
  assign y = y_q;
  assign y_valid = |y_q;
  assign done = done_q;
  assign busy = state_q != IDLE || pend_full;
endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// tb_onehot_pulse_decoder: scoreboard bench for onehot_pulse_decoder (P=4,G=1 and P=1,G=0 instances)
module tb_onehot_pulse_decoder;
  localparam int P = 4;
  localparam int G = 1;
`ifdef ONEHOT_DEC_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif
  typedef struct {
    logic [3:0] y;
    int c;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, v1 = 1'b0;
  logic [1:0] in_code = '0, c1 = '0;
  logic in_ready, y_valid, busy, done, r1, yv1, b1, d1;
  logic [3:0] y, y1;
  int cyc = 0, cmp = 0, mis = 0, nf = 0, nf1 = 0;
  exp_t sb[$], sb1[$];
  exp_t e0, e1;
  onehot_pulse_decoder #(.SEL_W(2), .PULSE_LEN(P), .GAP_LEN(G)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code), .in_ready(in_ready),
    .y(y), .y_valid(y_valid), .busy(busy), .done(done)
  );
  onehot_pulse_decoder #(.SEL_W(2), .PULSE_LEN(1), .GAP_LEN(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_code(c1), .in_ready(r1),
    .y(y1), .y_valid(yv1), .busy(b1), .done(d1)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk)
    if (!rst) begin
      chk("onehot", 32'($countones(y) <= 1), 1);
      chk("y_valid_eq", y_valid, y != 0);
      if (y_valid) begin
        if (sb.size() == 0) chk("unexpected_y", y, 0);
        else begin
          e0 = sb.pop_front();
          chk("y", y, e0.y);
          chk("y_cycle", cyc, e0.c);
        end
      end
      chk("u1_y_valid_eq", yv1, y1 != 0);
      if (yv1) begin
        if (sb1.size() == 0) chk("u1_unexpected_y", y1, 0);
        else begin
          e1 = sb1.pop_front();
          chk("u1_y", y1, e1.y);
          chk("u1_y_cycle", cyc, e1.c);
        end
      end
    end
  task automatic send(input logic [1:0] c, output int acc);
    int n = 0;
    int st;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_code = c;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", in_ready, 1);
    if (!in_ready) begin
      acc = -1;
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc - 1;
      st = cyc > nf ? cyc : nf;
      for (int j = 0; j < P; j++) begin
        e.y = 4'b1 << c;
        e.c = st + j;
        sb.push_back(e);
      end
      nf = st + P + G;
      in_valid = 1'b0;
      in_code = ~c;
    end
  endtask
  task automatic drain();
    int n = 0;
    while ((busy || b1 || sb.size() > 0 || sb1.size() > 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", n < 60, 1);
  endtask
  initial begin
    int a0, a3, fy, i, st;
    logic rr;
    exp_t e;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_y", y, 0);
      chk("rst_y_valid", y_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", in_ready, 0);
    end
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);
    send(2'd2, a0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("single_y", y, k <= 4 ? 4 : 0);
      chk("single_done", done, k == 5);
      chk("single_ready", in_ready, QUEUE || k == 6);
      chk("single_busy", busy, k <= 5);
    end
    for (int k = 0; k < 4; k++) send(2'(k), a0);
    drain();
    send(2'd0, a0);
    send(2'd3, a3);
    chk("hold_accept_cycle", a3 - a0, QUEUE ? 1 : 6);
    fy = -1;
    for (int k = 0; k < 20 && fy < 0; k++) begin
      @(negedge clk);
      if (y == 4'b1000) fy = cyc;
    end
    chk("hold_first_y", fy - a0, QUEUE ? 6 : 7);
    drain();
    send(2'd1, a0);
    @(negedge clk);
    in_valid = 1'b1;
    in_code = 2'd2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    nf = 0;
    #1;
    chk("midrst_y", y, 0);
    chk("midrst_y_valid", y_valid, 0);
    chk("midrst_ready", in_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("postrst_y", y, 0);
      chk("postrst_done", done, 0);
      chk("postrst_busy", busy, 0);
      chk("postrst_ready", in_ready, 1);
    end
    i = 0;
    for (int t = 0; t < 16 && i < 4; t++) begin
      @(negedge clk);
      v1 = 1'b1;
      c1 = 2'(i);
      rr = r1;
      chk("u1_ready", rr, QUEUE || t % 2 == 0);
      @(posedge clk);
      #1;
      if (rr) begin
        st = cyc > nf1 ? cyc : nf1;
        e.y = 4'b1 << i;
        e.c = st;
        sb1.push_back(e);
        nf1 = st + 1;
        i++;
      end
    end
    v1 = 1'b0;
    chk("u1_all_sent", i, 4);
    @(negedge clk);
    @(negedge clk);
    chk("u1_done", d1, 1);
    chk("u1_y_after", y1, 0);
    drain();
    chk("sb_empty", sb.size(), 0);
    chk("sb1_empty", sb1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
